axi4_burst_manager: RTL and testbench
=====================================

// Module: axi4_burst_manager
// PURPOSE
// - AXI4-full manager (initiator) that drives the S_AXI_* subordinate interface from a simple command/stream front end.
// - Single outstanding transaction, INCR bursts only.
// - Channel ordering: AW -> W burst -> B for writes; AR -> R burst for reads.
// - Reset and stability rules are those our subordinate assertion set enforces on the manager side.
// PARAMETERS
// - ADDR_WIDTH  4   byte address width of AWADDR/ARADDR
// - DATA_WIDTH  32  data width; WSTRB width = DATA_WIDTH/8
// - AXI_PROT    3'b000  constant value driven on AWPROT/ARPROT while the matching VALID is high
// PORTS
// - M_AXI_ACLK     in   1     single clock
// - M_AXI_ARESET   in   1     asynchronous, active-high reset
// - cmd_valid      in   1     command handshake, valid
// - cmd_ready      out  1     command handshake, ready
// - cmd_write      in   1     1 = write burst, 0 = read burst
// - cmd_addr       in   ADDR_WIDTH  start byte address
// - cmd_len        in   8     beats-1 (AxLEN)
// - wr_valid / wr_ready / wr_data  in/out/in  1/1/DATA_WIDTH  write beat stream
// - rd_valid / rd_ready            out/in     1/1             read beat stream
// - rd_data / rd_last              out        DATA_WIDTH/1    read beat payload and last flag
// - done           out  1     one-cycle pulse at end of a transaction
// - done_resp      out  2     worst (max) xRESP seen in the burst; valid with done
// - AWADDR/AWLEN/AWSIZE/AWBURST/AWPROT/AWVALID  out   write address channel
// - AWREADY                                     in    write address channel
// - WDATA/WSTRB/WLAST/WVALID                    out   write data channel
// - WREADY                                      in    write data channel
// - BRESP/BVALID                                in    write response channel
// - BREADY                                      out   write response channel
// - ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT/ARVALID  out   read address channel
// - ARREADY                                     in    read address channel
// - RDATA/RRESP/RLAST/RVALID                    in    read data channel
// - RREADY                                      out   read data channel
// BEHAVIOUR
// - Reset values: all VALID/READY outputs 0; ADDR/DATA/PROT/LEN/WSTRB/WLAST 0; cmd_ready 0; done 0.
// - Reset is asynchronous: assertion mid-burst aborts immediately, with no completion pulse.
// - Payload zeroing: ADDR, PROT, WDATA, WSTRB and WLAST read 0 whenever the matching VALID is 0.
// - FSM states IDLE, AW, W, B, AR, R.
//   - IDLE: cmd_ready=1. On cmd handshake, latch addr and len, clear the beat counter and resp, then go to AW (write) or AR (read).
//   - AW: AWVALID=1 with AWSIZE=log2(DATA_WIDTH/8) and AWBURST=2'b01. Hold all fields stable until AWREADY, then go to W.
//   - W: 1-entry holding register.
//     - wr_ready = !wfull | WREADY; load on wr handshake.
//     - WVALID = wfull; WDATA/WSTRB (all ones) stay stable while WVALID & !WREADY.
//     - WLAST = (beat == len). Count on W handshake; after the last beat, go to B.
//     - WVALID is never asserted before the AW handshake completes.
//   - B: BREADY=1. On BVALID, capture BRESP, pulse done for 1 cycle, return to IDLE.
//   - AR: same field and stability rules as AW; go to R on ARREADY.
//   - R: 1-entry output register.
//     - RREADY = !rd_valid | rd_ready.
//     - R handshake loads rd_data and rd_last; resp = max(resp, RRESP).
//     - On the handshake with RLAST: rd_last=1, done pulses in the cycle the final beat is presented on rd_valid, then go to IDLE once it is drained.
// - Beat counter is 8 bits and never wraps: len=255 gives exactly 256 beats.
// - RLAST arriving early or late against len is not corrected: the burst ends on RLAST.
// - Throughput: first AW/AR beat 1 cycle after the cmd handshake. Back-to-back beats at 1 per cycle when the peer is ready every cycle.
// STRUCTURE
// - Package axi4_mgr_pkg:
//   - state enum (IDLE, AW, W, B, AR, R)
//   - BURST_INCR=2'b01
//   - RESP_OKAY/EXOKAY/SLVERR/DECERR
//   - function size_enc(DATA_WIDTH)
// - One natural sub-module: axi4_mgr_beat_reg, a 1-entry valid/ready holding register with zero-when-empty payload. Instantiated for W and R.
// TESTING
// - Reset: hold M_AXI_ARESET 5 cycles, release -> all VALID=0, ADDR/WDATA/PROT=0, cmd_ready=1 next cycle.
// - Write, len=3, addr=4'h4, AWREADY delayed 3 cycles -> AWADDR stable 4 cycles; 4 W beats, WLAST on beat 4 only; BRESP=OKAY -> done=1, done_resp=0.
// - Read, len=0, RVALID with rd_ready=0 for 2 cycles -> RREADY low while buffer is full; rd_data holds; done pulses once.
// - WREADY toggling 1/0 during an 8-beat write -> no beat lost or duplicated; WDATA stable while stalled.
// - Read, len=1, RRESP=SLVERR on beat 1 -> done_resp=2'b10.
// - Reset asserted mid-W burst -> outputs zero asynchronously; no done; after release, next write completes normally.

Source files
------------

// File: rtl/axi4_mgr_pkg.sv
// Shared types and constants for the AXI4 burst manager.
// Contents: FSM state encoding, AXI burst/response codes, and the AxSIZE
// encoder used to derive the transfer size from the data-bus width.
package axi4_mgr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxSIZE = log2(bytes per beat); unsupported widths encode as 0.
  function automatic logic [2:0] size_enc(input int unsigned data_width);
    logic [2:0] enc;
    enc = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_width) enc = 3'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/axi4_mgr_beat_reg.sv
// One-entry valid/ready holding register with zero-when-empty payload.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready_c   upstream handshake (ready is combinational)
//   in_data               upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data              downstream payload, all zeros while empty
module axi4_mgr_beat_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready_c,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             full;
  logic [WIDTH-1:0] data;

  // Accept when empty, or when the current entry leaves this cycle.
  assign in_ready_c = !full || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready_c) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready) begin
      // Drained with nothing behind it: clear so the payload reads zero.
      full <= 1'b0;
      data <= '0;
    end
  end

  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/axi4_burst_manager.sv
// AXI4-full manager: single outstanding INCR burst driven from a command
// port plus write/read beat streams.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET        clock, asynchronous active-high reset
//   cmd_*                           command handshake (write flag, addr, len)
//   wr_valid/wr_ready/wr_data       write beat stream into the W channel
//   rd_valid/rd_ready/rd_data/rd_last  read beat stream out of the R channel
//   done/done_resp                  end-of-transaction pulse, worst response
//   AW*/W*/B*/AR*/R*                AXI4 manager-side channels
module axi4_burst_manager
  import axi4_mgr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic [2:0]              AWPROT,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic [2:0]              ARPROT,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [2:0] SIZE = size_enc(DATA_WIDTH);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;     // W handshakes completed
  logic [7:0]              load_q;     // beats accepted from wr stream
  logic                    load_done;  // all len+1 beats accepted
  logic                    rlast_seen;
  logic                    live;       // first cycle out of reset has passed
  logic [1:0]              resp_q;
  logic                    done_q;

  logic                    w_in_valid, w_in_ready_c, w_full;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    r_in_valid, r_in_ready_c;
  logic [DATA_WIDTH:0]     r_out;

  logic                    cmd_hs, w_hs, r_hs, rd_hs;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign w_hs   = WVALID && WREADY;
  assign r_hs   = RVALID && RREADY;
  assign rd_hs  = rd_valid && rd_ready;

  // Write beat buffer: only fills in W, and stops after len+1 beats.
  assign w_in_valid = wr_valid && (state == W) && !load_done;
  assign wr_ready   = (state == W) && !load_done && w_in_ready_c;

  axi4_mgr_beat_reg #(.WIDTH(DATA_WIDTH)) u_wbuf (
    .clk        (M_AXI_ACLK),
    .rst        (M_AXI_ARESET),
    .in_valid   (w_in_valid),
    .in_ready_c (w_in_ready_c),
    .in_data    (wr_data),
    .out_valid  (w_full),
    .out_ready  (WREADY),
    .out_data   (w_data)
  );

  assign WVALID = w_full;
  assign WDATA  = w_data;
  assign WSTRB  = w_full ? '1 : '0;
  assign WLAST  = w_full && (beat_q == len_q);

  // Read beat buffer: closes once the RLAST beat is captured.
  assign r_in_valid = RVALID && (state == R) && !rlast_seen;
  assign RREADY     = (state == R) && !rlast_seen && r_in_ready_c;

  axi4_mgr_beat_reg #(.WIDTH(DATA_WIDTH + 1)) u_rbuf (
    .clk        (M_AXI_ACLK),
    .rst        (M_AXI_ARESET),
    .in_valid   (r_in_valid),
    .in_ready_c (r_in_ready_c),
    .in_data    ({RLAST, RDATA}),
    .out_valid  (rd_valid),
    .out_ready  (rd_ready),
    .out_data   (r_out)
  );

  assign rd_data   = r_out[DATA_WIDTH-1:0];
  assign rd_last   = r_out[DATA_WIDTH];
  assign done      = done_q;
  assign done_resp = resp_q;

  // State register.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_hs)          state_nxt = cmd_write ? AW : AR;
      AW:   if (AWREADY)         state_nxt = W;
      W:    if (w_hs && WLAST)   state_nxt = B;
      B:    if (BVALID)          state_nxt = IDLE;
      AR:   if (ARREADY)         state_nxt = R;
      R:    if (rd_hs && rd_last) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Channel control outputs; address payload is zero unless VALID.
  always_comb begin
    cmd_ready = 1'b0;
    BREADY    = 1'b0;
    AWVALID   = 1'b0;
    AWADDR    = '0;
    AWLEN     = '0;
    AWSIZE    = '0;
    AWBURST   = '0;
    AWPROT    = '0;
    ARVALID   = 1'b0;
    ARADDR    = '0;
    ARLEN     = '0;
    ARSIZE    = '0;
    ARBURST   = '0;
    ARPROT    = '0;
    unique case (state)
      IDLE: cmd_ready = live;
      AW: begin
        AWVALID = 1'b1;
        AWADDR  = addr_q;
        AWLEN   = len_q;
        AWSIZE  = SIZE;
        AWBURST = BURST_INCR;
        AWPROT  = AXI_PROT;
      end
      B: BREADY = 1'b1;
      AR: begin
        ARVALID = 1'b1;
        ARADDR  = addr_q;
        ARLEN   = len_q;
        ARSIZE  = SIZE;
        ARBURST = BURST_INCR;
        ARPROT  = AXI_PROT;
      end
      default: ;
    endcase
  end

  // Transaction context, beat counters, response tracking, done pulse.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      load_q     <= '0;
      load_done  <= 1'b0;
      rlast_seen <= 1'b0;
      live       <= 1'b0;
      resp_q     <= RESP_OKAY;
      done_q     <= 1'b0;
    end else begin
      live   <= 1'b1;
      done_q <= 1'b0;
      if (cmd_hs) begin
        addr_q     <= cmd_addr;
        len_q      <= cmd_len;
        beat_q     <= '0;
        load_q     <= '0;
        load_done  <= 1'b0;
        rlast_seen <= 1'b0;
        resp_q     <= RESP_OKAY;
      end
      if (wr_valid && wr_ready) begin
        load_q <= load_q + 8'd1;
        if (load_q == len_q) load_done <= 1'b1;
      end
      if (w_hs) beat_q <= beat_q + 8'd1;
      if ((state == B) && BVALID) begin
        resp_q <= BRESP;
        done_q <= 1'b1;
      end
      if (r_hs) begin
        if (RRESP > resp_q) resp_q <= RRESP;
        // Burst length follows RLAST, not len.
        if (RLAST) begin
          rlast_seen <= 1'b1;
          done_q     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_manager.sv
// Scoreboard bench for axi4_burst_manager: directed commands push expected
// AW/W/AR/read-beat/done records; a negedge monitor pops and compares them
// whenever the DUT presents the corresponding output.
module tb_axi4_burst_manager;
  import axi4_mgr_pkg::*;

  typedef struct packed { logic [3:0] addr; logic [7:0] len; } a_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  done_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, RLAST, RVALID, RREADY;

  axi4_burst_manager #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .AXI_PROT(3'b000)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Scoreboard queues and stimulus sources.
  a_t        exp_aw[$], exp_ar[$];
  beat_t     exp_w[$], exp_rd[$];
  logic [1:0] exp_done[$];
  logic [31:0] wr_src[$];
  rbeat_t    r_q[$];

  int checks = 0;
  int errors = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  int post_rst = 0;

  // Subordinate model configuration.
  int         aw_delay, ar_delay;
  logic       w_toggle;
  logic [1:0] b_resp;

  // Handshakes sampled at negedge, consumed at the following posedge.
  logic aw_hs, w_hs, wlast_hs, b_hs, ar_hs, r_hs, rlast_hs, wr_hs;
  always @(negedge clk) begin
    aw_hs    = AWVALID && AWREADY;
    w_hs     = WVALID && WREADY;
    wlast_hs = WVALID && WREADY && WLAST;
    b_hs     = BVALID && BREADY;
    ar_hs    = ARVALID && ARREADY;
    r_hs     = RVALID && RREADY;
    rlast_hs = RVALID && RREADY && RLAST;
    wr_hs    = wr_valid && wr_ready;
  end

  // AXI subordinate model.
  int   awc, arc;
  logic b_owed, r_open;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
      RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
      awc = 0; arc = 0; b_owed = 0; r_open = 0;
    end else begin
      if (AWVALID) begin AWREADY = (awc >= aw_delay); awc++; end
      else begin AWREADY = 0; awc = 0; end
      if (ARVALID) begin ARREADY = (arc >= ar_delay); arc++; end
      else begin ARREADY = 0; arc = 0; end
      WREADY = w_toggle ? !WREADY : 1'b1;
      if (b_hs) BVALID = 0;
      if (wlast_hs) b_owed = 1;
      if (!BVALID && b_owed) begin BVALID = 1; BRESP = b_resp; b_owed = 0; end
      if (ar_hs) r_open = 1;
      if (r_hs) RVALID = 0;
      if (rlast_hs) r_open = 0;
      if (!RVALID) begin
        if (r_open && r_q.size() > 0) begin
          RVALID = 1; RDATA = r_q[0].data; RRESP = r_q[0].resp; RLAST = r_q[0].last;
          r_q.delete(0);
        end else begin
          RDATA = 0; RRESP = 0; RLAST = 0;
        end
      end
    end
  end

  // Write stream source.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      wr_valid = 0; wr_data = 0;
    end else begin
      if (wr_hs && wr_src.size() > 0) wr_src.delete(0);
      if (wr_src.size() > 0) begin wr_valid = 1; wr_data = wr_src[0]; end
      else begin wr_valid = 0; wr_data = 0; end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard.
  a_t    ma;
  beat_t mb;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_ctrl", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rd_valid,
                             cmd_ready, done, wr_ready}), 64'd0);
      chk("reset_payload", 64'({AWADDR, ARADDR, AWPROT, ARPROT, AWLEN, ARLEN,
                                WSTRB, WLAST}), 64'd0);
      chk("reset_wdata", 64'(WDATA), 64'd0);
      post_rst = 2;
    end else begin
      if (post_rst > 0) begin
        post_rst--;
        if (post_rst == 0) chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
      end
      if (AWVALID) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(AWVALID), 64'd0);
        else begin
          ma = exp_aw[0];
          chk("awaddr", 64'(AWADDR), 64'(ma.addr));
          chk("awlen", 64'(AWLEN), 64'(ma.len));
          chk("aw_size_burst_prot", 64'({AWSIZE, AWBURST, AWPROT}), 64'({3'd2, 2'b01, 3'b000}));
          if (AWREADY) exp_aw.delete(0);
        end
      end else chk("aw_idle_zero", 64'({AWADDR, AWPROT}), 64'd0);
      if (WVALID) begin
        chk("w_before_aw", 64'(exp_aw.size()), 64'd0);
        if (exp_w.size() == 0) chk("w_unexpected", 64'(WVALID), 64'd0);
        else begin
          mb = exp_w[0];
          chk("wdata", 64'(WDATA), 64'(mb.data));
          chk("wlast", 64'(WLAST), 64'(mb.last));
          chk("wstrb", 64'(WSTRB), 64'h0F);
          if (WREADY) exp_w.delete(0);
        end
      end else chk("w_idle_zero", 64'({WDATA, WSTRB, WLAST}), 64'd0);
      if (ARVALID) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(ARVALID), 64'd0);
        else begin
          ma = exp_ar[0];
          chk("araddr", 64'(ARADDR), 64'(ma.addr));
          chk("arlen", 64'(ARLEN), 64'(ma.len));
          chk("ar_size_burst_prot", 64'({ARSIZE, ARBURST, ARPROT}), 64'({3'd2, 2'b01, 3'b000}));
          if (ARREADY) exp_ar.delete(0);
        end
      end else chk("ar_idle_zero", 64'({ARADDR, ARPROT}), 64'd0);
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 64'(rd_valid), 64'd0);
        else begin
          mb = exp_rd[0];
          chk("rd_data", 64'(rd_data), 64'(mb.data));
          chk("rd_last", 64'(rd_last), 64'(mb.last));
          if (rd_ready) exp_rd.delete(0);
        end
        if (!rd_ready) chk("rready_when_full", 64'(RREADY), 64'd0);
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          chk("done_resp", 64'(done_resp), 64'(exp_done[0]));
          exp_done.delete(0);
        end
      end
      if (tmo_cnt != tmo_seen) begin
        chk("wait_timeout", 64'(tmo_cnt), 64'(tmo_seen));
        tmo_seen = tmo_cnt;
      end
    end
  end

  task automatic push_write(input logic [3:0] a, input logic [7:0] l,
                            input logic [31:0] base, input logic [1:0] br);
    a_t    x;
    beat_t b;
    x.addr = a; x.len = l;
    exp_aw.push_back(x);
    for (int i = 0; i <= int'(l); i++) begin
      b.data = base + 32'(i);
      b.last = (i == int'(l));
      wr_src.push_back(b.data);
      exp_w.push_back(b);
    end
    b_resp = br;
  endtask

  task automatic push_ar(input logic [3:0] a, input logic [7:0] l);
    a_t x;
    x.addr = a; x.len = l;
    exp_ar.push_back(x);
  endtask

  task automatic push_rbeat(input logic [31:0] d, input logic [1:0] rs, input logic lst);
    rbeat_t r;
    beat_t  b;
    r.data = d; r.resp = rs; r.last = lst;
    b.data = d; b.last = lst;
    r_q.push_back(r);
    exp_rd.push_back(b);
  endtask

  task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] l);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    if (n >= 50) tmo_cnt++;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rd.size()
            + exp_done.size()) != 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) tmo_cnt++;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_rd_valid();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 100);
    if (n >= 100) tmo_cnt++;
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    rd_ready = 1; aw_delay = 0; ar_delay = 0; w_toggle = 0; b_resp = RESP_OKAY;
    rst = 1;
    repeat (5) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);

    // Write len=3 @4, AWREADY after 3 stalled cycles, OKAY.
    aw_delay = 3;
    push_write(4'h4, 8'd3, 32'hA000_0000, RESP_OKAY);
    exp_done.push_back(RESP_OKAY);
    issue(1'b1, 4'h4, 8'd3);
    wait_done();
    aw_delay = 0;

    // Read len=0 @8 with rd_ready low for 2 cycles after presentation.
    rd_ready = 0;
    push_ar(4'h8, 8'd0);
    push_rbeat(32'hDEAD_BEEF, RESP_OKAY, 1'b1);
    exp_done.push_back(RESP_OKAY);
    issue(1'b0, 4'h8, 8'd0);
    wait_rd_valid();
    repeat (2) @(posedge clk);
    #1 rd_ready = 1;
    wait_done();

    // 8-beat write with WREADY toggling, EXOKAY.
    w_toggle = 1;
    push_write(4'h0, 8'd7, 32'h5A5A_0010, RESP_EXOKAY);
    exp_done.push_back(RESP_EXOKAY);
    issue(1'b1, 4'h0, 8'd7);
    wait_done();
    w_toggle = 0;

    // Read len=1 @C, SLVERR on the second beat, stalled consumer first.
    rd_ready = 0;
    push_ar(4'hC, 8'd1);
    push_rbeat(32'h1111_0001, RESP_OKAY, 1'b0);
    push_rbeat(32'h2222_0002, RESP_SLVERR, 1'b1);
    exp_done.push_back(RESP_SLVERR);
    issue(1'b0, 4'hC, 8'd1);
    wait_rd_valid();
    repeat (3) @(posedge clk);
    #1 rd_ready = 1;
    wait_done();

    // Reset mid-W burst: no done expected, queues dropped.
    push_write(4'h0, 8'd7, 32'hC000_0000, RESP_OKAY);
    issue(1'b1, 4'h0, 8'd7);
    begin
      int n;
      n = 0;
      while (exp_w.size() > 5 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) tmo_cnt++;
    end
    @(posedge clk); #2 rst = 1;
    repeat (3) @(posedge clk);
    exp_w.delete(); wr_src.delete(); exp_aw.delete();
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);

    // Normal write after reset, DECERR.
    push_write(4'h8, 8'd1, 32'h7E57_0000, RESP_DECERR);
    exp_done.push_back(RESP_DECERR);
    issue(1'b1, 4'h8, 8'd1);
    wait_done();

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
